// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: memory-op codes, FSM states and op decode helpers for the MEM stage.
package mem_stage_pkg;
   localparam logic [3:0] MEM_NOP = 4'd0;
   localparam logic [3:0] MEM_LB  = 4'd1;
   localparam logic [3:0] MEM_LH  = 4'd2;
   localparam logic [3:0] MEM_LW  = 4'd3;
   localparam logic [3:0] MEM_LBU = 4'd4;
   localparam logic [3:0] MEM_LHU = 4'd5;
   localparam logic [3:0] MEM_SB  = 4'd6;
   localparam logic [3:0] MEM_SH  = 4'd7;
   localparam logic [3:0] MEM_SW  = 4'd8;
   typedef enum logic {MEM_IDLE, MEM_ACC} mem_state_e;
   function automatic logic [2:0] op_bytes(input logic [3:0] op);
      return (op == MEM_LW || op == MEM_SW) ? 3'd4 :
             (op == MEM_LH || op == MEM_LHU || op == MEM_SH) ? 3'd2 : 3'd1;
   endfunction
   function automatic logic op_store(input logic [3:0] op);
      return op == MEM_SB || op == MEM_SH || op == MEM_SW;
   endfunction
endpackage

// File: rtl/mem_stage_load_extend.sv
// mem_stage_load_extend: sign/zero extension of assembled load bytes.
module mem_stage_load_extend
   import mem_stage_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [3:0]  op,
   output logic [31:0] res
);
   assign res = op == MEM_LB  ? {{24{raw[7]}}, raw[7:0]} :
                op == MEM_LH  ? {{16{raw[15]}}, raw[15:0]} :
                op == MEM_LBU ? {24'd0, raw[7:0]} :
                op == MEM_LHU ? {16'd0, raw[15:0]} : raw;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: byte-serial little-endian load/store stage with pipeline stall and MEM/WB register.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int MEM_ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4:0]            wd_i,
   input  logic                  wreg_i,
   input  logic [31:0]           wdata_i,
   input  logic [3:0]            mem_op_i,
   input  logic [31:0]           mem_addr_i,
   input  logic [31:0]           mem_sdata_i,
   input  logic                  mem_gnt_i,
   input  logic [7:0]            mem_din_i,
   output logic                  mem_req_o,
   output logic [MEM_ADDR_W-1:0] mem_a_o,
   output logic [7:0]            mem_dout_o,
   output logic                  mem_wr_o,
   output logic                  stallreq_o,
   output logic [4:0]            wd_o,
   output logic                  wreg_o,
   output logic [31:0]           wdata_o
);
   mem_state_e st, st_nx;
   logic [2:0] cnt, cnt_nx, n;
   logic [31:0] asm_buf, asm_full, ld_res, a_full;
   logic [4:0] byte_idx, cap_idx;
   logic is_mem, is_st, issue, done;
   assign is_mem = mem_op_i != MEM_NOP;
   assign is_st = op_store(mem_op_i);
   assign n = op_bytes(mem_op_i);
   assign a_full = mem_addr_i + {29'd0, cnt};
   assign byte_idx = {cnt[1:0], 3'b000};
   // In ACC, mem_din_i holds the byte issued the previous cycle (index cnt-1).
   assign cap_idx = {cnt[1:0] - 2'd1, 3'b000};
   assign issue = !rst && mem_gnt_i && is_mem && cnt < n;
   assign done = is_mem && (is_st ? issue && cnt == n - 3'd1 : st == MEM_ACC && cnt == n);
   always_comb begin
      asm_full = asm_buf;
      asm_full[cap_idx +: 8] = mem_din_i;
   end
   mem_stage_load_extend u_ext (.raw(asm_full), .op(mem_op_i), .res(ld_res));
   always_ff @(posedge clk) begin
      if (rst) begin
         st <= MEM_IDLE;
         cnt <= 3'd0;
      end else begin
         st <= st_nx;
         cnt <= cnt_nx;
      end
   end
   always_comb begin
      st_nx = done ? MEM_IDLE : issue ? MEM_ACC : st;
      cnt_nx = done ? 3'd0 : issue ? cnt + 3'd1 : cnt;
   end
   always_comb begin
      mem_req_o = !rst && (is_mem || st == MEM_ACC);
      stallreq_o = !rst && is_mem && !done;
      mem_wr_o = issue && is_st;
      mem_a_o = issue ? a_full[MEM_ADDR_W-1:0] : '0;
      mem_dout_o = (issue && is_st) ? mem_sdata_i[byte_idx +: 8] : 8'd0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         asm_buf <= 32'd0;
         wd_o <= 5'd0;
         wreg_o <= 1'b0;
         wdata_o <= 32'd0;
      end else begin
         if (st == MEM_ACC && !is_st) asm_buf[cap_idx +: 8] <= mem_din_i;
         wd_o <= stallreq_o ? 5'd0 : wd_i;
         wreg_o <= stallreq_o ? 1'b0 : wreg_i;
         wdata_o <= stallreq_o ? 32'd0 : !is_mem ? wdata_i : is_st ? 32'd0 : ld_res;
      end
   end
   // Grant is guaranteed held for the whole access once issued.
   a_gnt_held: assert property (@(posedge clk) disable iff (rst) st == MEM_ACC |-> mem_gnt_i);
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage; its inputs come from the EX/MEM pipeline register.
- Performs loads and stores over the shared byte-wide synchronous RAM port, one byte per cycle, little-endian.
- Stalls the pipeline while an access is in flight.
- Owns the MEM/WB output register feeding write-back; non-memory instructions pass through with 1-cycle latency.

Parameters:
MEM_ADDR_W, 32, width of mem_a_o; byte address = low MEM_ADDR_W bits of the computed address.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high (`RstEnable` = 1'b1)
wd_i  in  5  destination register address from EX/MEM
wreg_i  in  1  register write enable from EX/MEM
wdata_i  in  32  ALU result from EX/MEM
mem_op_i  in  4  memory op (`MemOpBus`): NOP, LB, LH, LW, LBU, LHU, SB, SH, SW
mem_addr_i  in  32  byte address of the access
mem_sdata_i  in  32  store data (rs2 value)
mem_gnt_i  in  1  RAM port granted to this stage
mem_din_i  in  8  RAM read data; valid the cycle after its address
mem_req_o  out  1  port request; high while a memory op is pending or in flight
mem_a_o  out  MEM_ADDR_W  RAM byte address
mem_dout_o  out  8  RAM write data
mem_wr_o  out  1  RAM write strobe
stallreq_o  out  1  stall request to pipeline control
wd_o  out  5  registered destination address to WB
wreg_o  out  1  registered write enable to WB
wdata_o  out  32  registered write-back data

Behaviour:
- Reset (rst=1 at a clk edge):
  - state := IDLE, cnt := 0, assembly buffer := 0.
  - wd_o, wreg_o, wdata_o := 0.
  - While rst=1, mem_wr_o, mem_req_o and stallreq_o are forced 0; mem_a_o and mem_dout_o are 0.
- Input stability: pipeline control holds the EX/MEM inputs stable while stallreq_o=1. The block does not re-latch them.
- Byte count n: 1 for B/BU, 2 for H/HU, 4 for W.
- Byte k uses address mem_addr_i+k, modulo 2^32, then truncated to MEM_ADDR_W. No alignment check; misaligned accesses are legal.
- States:
  - IDLE: waiting; byte 0 is issued from here.
  - ACC: bytes 1..n-1, then final load capture.
  - cnt (3 bits) counts bytes issued.
- NOP in IDLE:
  - mem_req_o=0, stallreq_o=0, no bus activity.
  - At the edge: wd_o<=wd_i, wreg_o<=wreg_i, wdata_o<=wdata_i.
- Memory op in IDLE with mem_gnt_i=0:
  - mem_req_o=1, stallreq_o=1, mem_wr_o=0; remain IDLE.
- Memory op in IDLE with mem_gnt_i=1 (cycle T):
  - Drive byte 0.
  - Store: mem_wr_o=1, mem_dout_o=mem_sdata_i[7:0].
  - Go to ACC with cnt=1, unless the op is SB.
- Load timing:
  - Cycles T..T+n-1: issue addresses, mem_wr_o=0.
  - Cycle T+n: no address issued; final byte captured from mem_din_i.
  - stallreq_o=1 in T..T+n-1 and 0 in T+n.
  - Edge ending T+n: wdata_o := assembled value, extended; state := IDLE.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW takes the word unchanged.
- Store timing:
  - Cycles T..T+n-1: mem_wr_o=1 and mem_dout_o=mem_sdata_i[8k+7:8k].
  - stallreq_o=1 in T..T+n-2 and 0 in T+n-1.
  - SB: no stall; completes in a single cycle from IDLE.
- Output register while stalled: any edge with stallreq_o=1 loads a bubble (wreg_o=0, wd_o=0, wdata_o=0).
- Output register when an op completes:
  - wd_o<=wd_i, wreg_o<=wreg_i.
  - Stores: wdata_o<=0; stores with wreg_i=1 are illegal from decode.
- Grant rule: once issued, mem_gnt_i is guaranteed held until the op finishes. Grant loss mid-op is an assertion failure, not handled.
- Back-to-back ops: a new memory op presented the cycle after completion starts from IDLE immediately. There are no idle bus cycles between consecutive stores.
- Reset mid-operation: access aborts at that edge.
  - Bytes already written stay written.
  - No further writes; state IDLE; no WB write for the aborted op.

Decomposition:
- Shared constants go in define.v: `MemOpBus` (3:0) and op codes `MEM_NOP`, `MEM_LB`, `MEM_LH`, `MEM_LW`, `MEM_LBU`, `MEM_LHU`, `MEM_SB`, `MEM_SH`, `MEM_SW`.
- Also from define.v: existing `RstEnable`, `ZeroWord`, `RegBus`, `RegAddrBus`; new state encodings `MEM_IDLE`, `MEM_ACC`.
- One sub-module, load_extend (combinational): 32-bit assembled bytes + op → extended 32-bit result.

Test Plan:
- ALU pass-through: NOP, wd_i=5, wreg_i=1, wdata_i=0x1234 → next cycle wd_o=5, wreg_o=1, wdata_o=0x1234; stallreq_o never high.
- LW: addr 0x100, RAM bytes 0x78,0x56,0x34,0x12 → mem_a_o 0x100..0x103 on T..T+3; stallreq_o high 4 cycles; wdata_o=0x12345678 at T+5.
- LB vs LBU: byte 0x80 at 0x20 → LB gives 0xFFFFFF80, LBU gives 0x00000080; stallreq_o high exactly 1 cycle.
- SW: sdata 0xDEADBEEF at 0x40 → writes EF,BE,AD,DE to 0x40..0x43 on consecutive cycles; stallreq_o high 3 cycles. SB → one write, no stall.
- Grant wait: LH with mem_gnt_i=0 for 3 cycles → no bus activity, stallreq_o=1 and bubbles on output; access starts the cycle gnt rises.
- Reset mid-SW: rst after the second byte → only 2 bytes written, no writes afterward, state IDLE, outputs zero.
